// File: rtl/seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_mux
// Purpose  : Time-multiplexed scanner for a multi-digit 7-segment display.
//            Steps through the digits of a held hex value and presents the
//            current nibble to the downstream 4-to-7 decoder. Each digit is
//            shown for TICK_DIV cycles. Between digits, BLANK_CYCLES cycles
//            have every digit enable off to prevent ghosting. A new value is
//            swapped in only at a frame boundary, so a frame never tears.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   1              system clock, rising edge
//   rst         in   1              asynchronous active-high reset
//   value_in    in   4*NUM_DIGITS   hex value, nibble i -> digit i (0 = LSD)
//   load        in   1              single-cycle strobe capturing value_in
//   digit_data  out  4              nibble of the current digit
//   digit_en    out  NUM_DIGITS     one-hot digit enable, all zero when blank
//   frame_start out  1              pulse on the first SHOW cycle of digit 0
//   pending     out  1              a loaded value awaits the next frame
// Build option:
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN - blank leading-zero digits (digit 0 is
//   always shown); timing, digit_data and frame_start are unaffected.
// ============================================================================
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic [3:0]              digit_data,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int c_idx_w   = $clog2(NUM_DIGITS);
    localparam int c_cnt_max = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(TICK_DIV - 1);
    // BLANK is unreachable when BLANK_CYCLES is 0; keep the constant legal.
    localparam logic [c_cnt_w-1:0] c_blank_last =
        c_cnt_w'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_SHOW  = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;

    logic [0:0]              r_state_q,   w_state_d;
    logic [c_idx_w-1:0]      r_idx_q,     w_idx_d;
    logic [c_cnt_w-1:0]      r_cnt_q,     w_cnt_d;
    logic [4*NUM_DIGITS-1:0] r_active_q,  w_active_d;
    logic [4*NUM_DIGITS-1:0] r_pend_q,    w_pend_d;
    logic                    r_flag_q,    w_flag_d;
    logic                    r_fstart_q,  w_fstart_d;

    logic                    w_advance;
    logic                    w_boundary;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [NUM_DIGITS-1:0]   w_show_mask;

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q + c_cnt_one;
        w_idx_d    = r_idx_q;
        w_advance  = 1'b0;

        case (r_state_q)
            ST_SHOW: begin
                if (r_cnt_q == c_tick_last) begin
                    w_cnt_d = '0;
                    if (BLANK_CYCLES > 0) begin
                        w_state_d = ST_BLANK;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                if (r_cnt_q == c_blank_last) begin
                    w_cnt_d   = '0;
                    w_advance = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_SHOW;
                w_cnt_d   = '0;
            end
        endcase

        if (w_advance) begin
            w_state_d = ST_SHOW;
            w_idx_d   = (r_idx_q == c_idx_last) ? '0 : (r_idx_q + c_idx_one);
        end

        w_boundary = w_advance && (r_idx_q == c_idx_last);

        // A load on the boundary edge bypasses the pending register and
        // becomes active at once; otherwise a waiting value is promoted.
        w_active_d = r_active_q;
        w_pend_d   = load ? value_in : r_pend_q;
        w_flag_d   = r_flag_q;
        if (w_boundary) begin
            if (load) begin
                w_active_d = value_in;
            end else if (r_flag_q) begin
                w_active_d = r_pend_q;
            end
            w_flag_d = 1'b0;
        end else if (load) begin
            w_flag_d = 1'b1;
        end

        // Registered so the pulse lines up with the first SHOW cycle of
        // digit 0 and never fires on the post-reset frame.
        w_fstart_d = w_boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= ST_SHOW;
            r_idx_q    <= '0;
            r_cnt_q    <= '0;
            r_active_q <= '0;
            r_pend_q   <= '0;
            r_flag_q   <= 1'b0;
            r_fstart_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_idx_q    <= w_idx_d;
            r_cnt_q    <= w_cnt_d;
            r_active_q <= w_active_d;
            r_pend_q   <= w_pend_d;
            r_flag_q   <= w_flag_d;
            r_fstart_q <= w_fstart_d;
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Digit i is a leading zero when nibbles i..NUM_DIGITS-1 are all zero.
    assign w_show_mask[0] = 1'b1;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz_mask
        assign w_show_mask[gi] = |r_active_q[4*NUM_DIGITS-1:4*gi];
    end
`else
    assign w_show_mask = '1;
`endif

    assign w_onehot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx_q;
    assign digit_en    = (r_state_q == ST_SHOW) ? (w_onehot & w_show_mask) : '0;
    assign digit_data  = r_active_q[{r_idx_q, 2'b00} +: 4];
    assign frame_start = r_fstart_q;
    assign pending     = r_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_mux
// Purpose  : Self-checking bench for seven_seg_scan_mux (4 digits, 4-cycle
//            digit time, 2 blank cycles -> 24-cycle frame). A frame-position
//            reference model produces the expected outputs for every cycle;
//            they are queued when stimulus is driven and compared after the
//            clock edge. Honours SEVEN_SEG_LEADING_ZERO_BLANK_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_mux;

    localparam int NUM_DIGITS   = 4;
    localparam int TICK_DIV     = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int c_slot       = TICK_DIV + BLANK_CYCLES;
    localparam int c_frame      = NUM_DIGITS * c_slot;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  digit_data;
    logic [3:0]  digit_en;
    logic        frame_start;
    logic        pending;

    seven_seg_scan_mux #(
        .NUM_DIGITS   (NUM_DIGITS),
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .load        (load),
        .digit_data  (digit_data),
        .digit_en    (digit_en),
        .frame_start (frame_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] data;
        logic       pend;
        logic       fs;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: position within the frame plus value bookkeeping.
    int          m_pos;
    logic [15:0] m_active;
    logic [15:0] m_pend;
    logic        m_flag;
    logic        m_fs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_active = '0; m_pend = '0; m_flag = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] v);
        logic bnd;
        bnd = (m_pos == c_frame - 1);
        if (bnd) begin
            if (ld) m_active = v;
            else if (m_flag) m_active = m_pend;
            m_flag = 1'b0;
        end else if (ld) begin
            m_pend = v;
            m_flag = 1'b1;
        end
        m_fs  = bnd;
        m_pos = (m_pos + 1) % c_frame;
    endtask

    task automatic push_exp();
        exp_t e;
        int   slot;
        int   w;
        slot   = m_pos / c_slot;
        w      = m_pos % c_slot;
        e.en   = (w < TICK_DIV) ? 4'(1 << slot) : 4'h0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_active >> (4 * slot)) == 16'h0) e.en = 4'h0;
`endif
        e.data = m_active[4*slot +: 4];
        e.pend = m_flag;
        e.fs   = m_fs;
        q_exp.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (q_exp.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            check({tag, "_en"},   32'(digit_en),    32'(e.en));
            check({tag, "_data"}, 32'(digit_data),  32'(e.data));
            check({tag, "_pend"}, 32'(pending),     32'(e.pend));
            check({tag, "_fs"},   32'(frame_start), 32'(e.fs));
        end
    endtask

    // One clock: drive at the falling edge, compare 1 ns after the rising edge.
    task automatic step(input logic ld, input logic [15:0] v);
        @(negedge clk);
        load     = ld;
        value_in = v;
        model_edge(ld, v);
        push_exp();
        @(posedge clk);
        #1;
        load = 1'b0;
        pop_cmp("scan");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic go_pos(input int p);
        for (int i = 0; i < c_frame && m_pos != p; i++) step(1'b0, 16'h0);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value_in = '0;
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        push_exp();
        pop_cmp("reset");
        #1 rst = 1'b0;

        // Free-running scan of zeros across the first boundary.
        run(30);

        // Scan order with 1234.
        step(1'b1, 16'h1234);
        run(40);

        // Deferred update mid-frame.
        go_pos(8);
        step(1'b1, 16'hABCD);
        check("defer_pend", 32'(pending), 32'd1);
        run(30);

        // Two loads before the boundary: last one wins.
        go_pos(5);
        step(1'b1, 16'h1111);
        run(5);
        step(1'b1, 16'h2222);
        run(30);

        // Load on the exact boundary edge with nothing pending.
        go_pos(c_frame - 1);
        step(1'b1, 16'h5A5A);
        check("coll_data", 32'(digit_data), 32'hA);
        check("coll_pend", 32'(pending), 32'd0);
        run(10);

        // Boundary load while another value is pending.
        go_pos(10);
        step(1'b1, 16'h0F0F);
        go_pos(c_frame - 1);
        step(1'b1, 16'h1357);
        check("coll2_data", 32'(digit_data), 32'h7);
        run(30);

        // Async reset during BLANK of digit 2 with a value pending.
        go_pos(14);
        step(1'b1, 16'hBEEF);
        go_pos(2 * c_slot + TICK_DIV);
        check("pre_rst_blank", 32'(digit_en), 32'd0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        push_exp();
        pop_cmp("async_rst");
        #1 rst = 1'b0;
        run(30);

        // Leading-zero values (zeros shown unless the option is built in).
        step(1'b1, 16'h0050);
        run(2 * c_frame);
        step(1'b1, 16'h0000);
        run(2 * c_frame);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
